// File: rtl/midi_note_ctrl.sv
// Monophonic MIDI note controller: parses a channel-voice byte stream with running status
// and drives a last-note-priority gate/note/velocity to the phase-accumulator bank.
module midi_note_ctrl #(
    parameter int CHANNEL = 0,
    parameter bit OMNI    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic       o_cmd,
    output logic [6:0] o_midi,
    output logic [6:0] o_velocity,
    output logic       o_err
);

    localparam logic [3:0] CH = CHANNEL[3:0];

    typedef enum logic [2:0] {
        NO_STATUS,
        WAIT_D1,
        WAIT_D2,
        SKIP1,
        SKIP2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] rs_type, rs_type_nxt;
    logic       rs_match, rs_match_nxt;
    logic       sysex, sysex_nxt;
    logic [6:0] d1, d1_nxt;
    logic       cmd_nxt;
    logic [6:0] midi_nxt, vel_nxt;
    logic       err_nxt;
    logic       is_rt, is_status, is_common, ch_match;

    // First state after a channel status byte (or after a skipped message completes).
    function automatic state_t start_state(input logic [3:0] t, input logic m);
        case (t)
            4'h8, 4'h9, 4'hB: start_state = m ? WAIT_D1 : SKIP2;
            4'hC, 4'hD:       start_state = SKIP1;
            default:          start_state = SKIP2;
        endcase
    endfunction

    assign is_rt     = (i_byte[7:3] == 5'b11111);
    assign is_status = i_byte[7];
    assign is_common = (i_byte[7:4] == 4'hF);
    assign ch_match  = OMNI || (i_byte[3:0] == CH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= NO_STATUS;
            rs_type    <= 4'h0;
            rs_match   <= 1'b0;
            sysex      <= 1'b0;
            d1         <= 7'h00;
            o_cmd      <= 1'b0;
            o_midi     <= 7'h00;
            o_velocity <= 7'h00;
            o_err      <= 1'b0;
        end else begin
            state      <= state_nxt;
            rs_type    <= rs_type_nxt;
            rs_match   <= rs_match_nxt;
            sysex      <= sysex_nxt;
            d1         <= d1_nxt;
            o_cmd      <= cmd_nxt;
            o_midi     <= midi_nxt;
            o_velocity <= vel_nxt;
            o_err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rs_type_nxt  = rs_type;
        rs_match_nxt = rs_match;
        sysex_nxt    = sysex;
        d1_nxt       = d1;
        cmd_nxt      = o_cmd;
        midi_nxt     = o_midi;
        vel_nxt      = o_velocity;
        err_nxt      = 1'b0;

        if (i_valid && !is_rt) begin
            if (is_status) begin
                if (is_common) begin
                    state_nxt    = NO_STATUS;
                    rs_type_nxt  = 4'h0;
                    rs_match_nxt = 1'b0;
                    sysex_nxt    = (i_byte[3:0] == 4'h0);
                end else begin
                    rs_type_nxt  = i_byte[7:4];
                    rs_match_nxt = ch_match;
                    sysex_nxt    = 1'b0;
                    state_nxt    = start_state(i_byte[7:4], ch_match);
                end
            end else begin
                case (state)
                    NO_STATUS: err_nxt = !sysex;
                    WAIT_D1: begin
                        d1_nxt    = i_byte[6:0];
                        state_nxt = WAIT_D2;
                    end
                    WAIT_D2: begin
                        // Only matched 8/9/B messages ever reach WAIT_D2.
                        state_nxt = WAIT_D1;
                        if (rs_type == 4'h9 && i_byte[6:0] != 7'h00) begin
                            if (d1 == 7'h7F) begin
                                err_nxt = 1'b1;
                            end else begin
                                cmd_nxt  = 1'b1;
                                midi_nxt = d1;
                                vel_nxt  = i_byte[6:0];
                            end
                        end else if (rs_type == 4'h8 || rs_type == 4'h9) begin
                            if (o_cmd && d1 == o_midi) begin
                                cmd_nxt = 1'b0;
                            end
                        end else if (rs_type == 4'hB) begin
                            if (d1 == 7'h7B || d1 == 7'h78) begin
                                cmd_nxt = 1'b0;
                            end
                        end
                    end
                    SKIP2:   state_nxt = SKIP1;
                    SKIP1:   state_nxt = start_state(rs_type, rs_match);
                    default: state_nxt = NO_STATUS;
                endcase
            end
        end
    end

endmodule
